// File: rtl/param_commit_ctrl.sv
// Reads a seqlock-guarded parameter block from on-chip memory and hands a
// consistent snapshot to the ODE solver, switching sets only at step boundaries.
module param_commit_ctrl #(
  parameter int NUM_PARAMS = 12,
  parameter int PARAM_W    = 10,
  parameter int ADDR_W     = 4,
  parameter int READ_LAT   = 1
) (
  input  logic                          clock_50,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [15:0]                   read_data,
  input  logic                          step_boundary,
  output logic [ADDR_W-1:0]             read_address,
  output logic [NUM_PARAMS*PARAM_W-1:0] params_out,
  output logic                          params_valid,
  output logic                          commit_pulse,
  output logic [7:0]                    retry_count
);

  localparam int                 WAIT_W    = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(READ_LAT);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NUM_PARAMS);

  typedef enum logic [2:0] {IDLE, SEQ0, SWEEP, SEQ1, CHECK, PENDING} state_t;

  state_t                        state;
  logic [WAIT_W-1:0]             wait_cnt;
  logic [15:0]                   seq0;
  logic [15:0]                   seq1;
  logic [15:0]                   last_seq;
  logic [NUM_PARAMS*PARAM_W-1:0] shadow;
  logic                          word_done;

  assign word_done = (wait_cnt == WAIT_LAST);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic state_t after_sweep(input logic en);
    return en ? SEQ0 : IDLE;
  endfunction

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      read_address <= '0;
      seq0         <= '0;
      seq1         <= '0;
      last_seq     <= 16'hFFFF;
      shadow       <= '0;
      params_out   <= '0;
      params_valid <= 1'b0;
      commit_pulse <= 1'b0;
      retry_count  <= '0;
    end else begin
      commit_pulse <= 1'b0;
      case (state)
        IDLE: begin
          read_address <= '0;
          wait_cnt     <= '0;
          if (enable) state <= SEQ0;
        end

        SEQ0: begin
          if (word_done) begin
            seq0     <= read_data;
            wait_cnt <= '0;
            if (enable) begin
              state        <= SWEEP;
              read_address <= ADDR_W'(1);
            end else begin
              state        <= IDLE;
              read_address <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        SWEEP: begin
          if (word_done) begin
            for (int k = 0; k < NUM_PARAMS; k++) begin
              if (read_address == ADDR_W'(k + 1))
                shadow[k*PARAM_W +: PARAM_W] <= read_data[PARAM_W-1:0];
            end
            wait_cnt <= '0;
            // The last parameter address is never exceeded; the seq word follows.
            if (!enable) begin
              state        <= IDLE;
              read_address <= '0;
            end else if (read_address == LAST_ADDR) begin
              state        <= SEQ1;
              read_address <= '0;
            end else begin
              read_address <= read_address + ADDR_W'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        SEQ1: begin
          if (word_done) begin
            seq1     <= read_data;
            wait_cnt <= '0;
            state    <= enable ? CHECK : IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        CHECK: begin
          read_address <= '0;
          wait_cnt     <= '0;
          if ((seq0 != seq1) || seq0[0]) begin
            retry_count <= sat_inc8(retry_count);
            state       <= after_sweep(enable);
          end else if (seq0 == last_seq) begin
            state <= after_sweep(enable);
          end else begin
            state <= PENDING;
          end
        end

        PENDING: begin
          read_address <= '0;
          wait_cnt     <= '0;
          if (step_boundary) begin
            params_out   <= shadow;
            last_seq     <= seq0;
            params_valid <= 1'b1;
            commit_pulse <= 1'b1;
            state        <= after_sweep(enable);
          end
        end

        default: begin
          state        <= IDLE;
          read_address <= '0;
          wait_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_commit_ctrl.sv
// Directed bench: a 1-cycle-latency instance for commit/retry/reset scenarios and a
// 3-cycle-latency instance for enable drop and retry saturation.
module tb_param_commit_ctrl;

  localparam int NP = 12;
  localparam int PW = 10;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A (READ_LAT=1)
  logic             reset_a = 1'b1;
  logic             enable_a = 1'b0;
  logic             sb_a = 1'b0;
  logic [15:0]      rd_a;
  logic [AW-1:0]    addr_a;
  logic [NP*PW-1:0] params_a;
  logic             valid_a, commit_a;
  logic [7:0]       retry_a;
  logic [15:0]      mem_a [16];

  // Instance B (READ_LAT=3)
  logic             reset_b = 1'b1;
  logic             enable_b = 1'b0;
  logic             sb_b = 1'b0;
  logic [15:0]      rd_b;
  logic [AW-1:0]    addr_b;
  logic [NP*PW-1:0] params_b;
  logic             valid_b, commit_b;
  logic [7:0]       retry_b;
  logic [15:0]      mem_b [16];
  logic [15:0]      pipe_b [3];

  param_commit_ctrl #(.NUM_PARAMS(NP), .PARAM_W(PW), .ADDR_W(AW), .READ_LAT(1)) dut_a (
    .clock_50(clk), .reset(reset_a), .enable(enable_a), .read_data(rd_a),
    .step_boundary(sb_a), .read_address(addr_a), .params_out(params_a),
    .params_valid(valid_a), .commit_pulse(commit_a), .retry_count(retry_a)
  );

  param_commit_ctrl #(.NUM_PARAMS(NP), .PARAM_W(PW), .ADDR_W(AW), .READ_LAT(3)) dut_b (
    .clock_50(clk), .reset(reset_b), .enable(enable_b), .read_data(rd_b),
    .step_boundary(sb_b), .read_address(addr_b), .params_out(params_b),
    .params_valid(valid_b), .commit_pulse(commit_b), .retry_count(retry_b)
  );

  always @(posedge clk) rd_a <= mem_a[addr_a];

  always @(posedge clk) begin
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rd_b = pipe_b[2];

  int n_commit_a = 0;
  int n_commit_b = 0;
  always @(posedge clk) begin
    if (commit_a) n_commit_a <= n_commit_a + 1;
    if (commit_b) n_commit_b <= n_commit_b + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic periodic = 1'b0;

  task automatic run_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 200000) begin
      if (periodic) sb_a = (cyc % 10 == 0);
      @(negedge clk);
      guard++;
    end
    if (periodic) sb_a = 1'b0;
    if (guard >= 200000) check_val("run_to_timeout", 128'(1), 128'(0));
  endtask

  logic [NP*PW-1:0] exp_p1, exp_p2;
  int base, base_b, r, t0;

  initial begin
    for (int k = 0; k < 16; k++) begin
      mem_a[k] = 16'h0;
      mem_b[k] = 16'h0;
    end
    mem_a[0] = 16'd2;
    mem_b[0] = 16'd2;
    for (int k = 0; k < NP; k++) begin
      mem_a[k+1] = 16'(k + 1);
      mem_b[k+1] = 16'(k + 1);
      exp_p1[k*PW +: PW] = PW'(k + 1);
      exp_p2[k*PW +: PW] = PW'(40 * (k + 1));
    end

    repeat (3) @(negedge clk);
    check_val("rst_addr",   128'(addr_a),   128'(0));
    check_val("rst_params", 128'(params_a), 128'(0));
    check_val("rst_valid",  128'(valid_a),  128'(0));
    check_val("rst_commit", 128'(commit_a), 128'(0));
    check_val("rst_retry",  128'(retry_a),  128'(0));
    check_val("rst_b_addr", 128'(addr_b),   128'(0));
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);

    // Test 1: first sweep and commit
    base = cyc + 1;
    enable_a = 1'b1;
    run_to(base);      check_val("t1_seq0_addr", 128'(addr_a), 128'(0));
    run_to(base + 2);  check_val("t1_addr1",     128'(addr_a), 128'(1));
    run_to(base + 9);  sb_a = 1'b1;
    run_to(base + 10); sb_a = 1'b0;
    run_to(base + 24); check_val("t1_addr12",    128'(addr_a), 128'(12));
    run_to(base + 26); check_val("t1_seq1_addr", 128'(addr_a), 128'(0));
    run_to(base + 38);
    check_val("t1_pend_valid",  128'(valid_a),    128'(0));
    check_val("t1_pend_params", 128'(params_a),   128'(0));
    check_val("t1_pend_addr",   128'(addr_a),     128'(0));
    check_val("t1_no_early",    128'(n_commit_a), 128'(0));
    run_to(base + 39); sb_a = 1'b1;
    run_to(base + 40); sb_a = 1'b0;
    check_val("t1_commit",  128'(commit_a), 128'(1));
    check_val("t1_valid",   128'(valid_a),  128'(1));
    check_val("t1_params",  128'(params_a), 128'(exp_p1));
    run_to(base + 41); check_val("t1_pulse_end", 128'(commit_a), 128'(0));

    // Test 4: unchanged seq, boundaries every 10 cycles
    periodic = 1'b1;
    run_to(base + 127);
    check_val("t4_retry",   128'(retry_a),    128'(0));
    check_val("t4_commits", 128'(n_commit_a), 128'(1));

    // Test 2: odd seq held
    mem_a[0] = 16'd3;
    run_to(base + 155); check_val("t2_retry0", 128'(retry_a), 128'(0));
    run_to(base + 156); check_val("t2_retry1", 128'(retry_a), 128'(1));
    run_to(base + 214);
    periodic = 1'b0;
    check_val("t2_retry3",   128'(retry_a),    128'(3));
    check_val("t2_commits",  128'(n_commit_a), 128'(1));
    check_val("t2_params",   128'(params_a),   128'(exp_p1));

    // Test 3: torn write, then a clean sweep of new values
    mem_a[0] = 16'd4;
    run_to(base + 227);
    mem_a[0] = 16'd6;
    for (int k = 1; k <= NP; k++) mem_a[k] = 16'hA000 + 16'(40 * k);
    run_to(base + 242); check_val("t3_retry_pre",  128'(retry_a), 128'(3));
    run_to(base + 243); check_val("t3_retry_torn", 128'(retry_a), 128'(4));
    run_to(base + 275);
    check_val("t3_pend_addr",   128'(addr_a),   128'(0));
    check_val("t3_pend_params", 128'(params_a), 128'(exp_p1));
    check_val("t3_pend_commit", 128'(commit_a), 128'(0));
    run_to(base + 279); sb_a = 1'b1;
    run_to(base + 280); sb_a = 1'b0;
    check_val("t3_commit", 128'(commit_a), 128'(1));
    check_val("t3_params", 128'(params_a), 128'(exp_p2));
    check_val("t3_retry",  128'(retry_a),  128'(4));
    mem_a[0] = 16'd8;
    run_to(base + 283); check_val("t3_commits", 128'(n_commit_a), 128'(2));

    // Test 5: reset while PENDING
    run_to(base + 312);
    check_val("t5_pend_addr", 128'(addr_a), 128'(0));
    reset_a = 1'b1;
    #1;
    check_val("t5_rst_params", 128'(params_a), 128'(0));
    check_val("t5_rst_valid",  128'(valid_a),  128'(0));
    check_val("t5_rst_retry",  128'(retry_a),  128'(0));
    check_val("t5_rst_commit", 128'(commit_a), 128'(0));
    run_to(base + 314);
    reset_a = 1'b0;
    r = cyc;
    run_to(r + 5);  sb_a = 1'b1;
    run_to(r + 6);  sb_a = 1'b0;
    run_to(r + 29);
    check_val("t5_no_commit", 128'(n_commit_a), 128'(2));
    check_val("t5_valid0",    128'(valid_a),    128'(0));
    run_to(r + 30); sb_a = 1'b1;
    run_to(r + 31); sb_a = 1'b0;
    check_val("t5_commit", 128'(commit_a), 128'(1));
    check_val("t5_valid",  128'(valid_a),  128'(1));
    check_val("t5_params", 128'(params_a), 128'(exp_p2));

    // Test 6: READ_LAT=3, enable drop mid-sweep, retry saturation
    base_b = cyc + 1;
    enable_b = 1'b1;
    run_to(base_b + 9);  enable_b = 1'b0;
    run_to(base_b + 11); check_val("t6_inflight_addr", 128'(addr_b), 128'(2));
    run_to(base_b + 12); check_val("t6_idle_addr",     128'(addr_b), 128'(0));
    run_to(base_b + 20); check_val("t6_idle_hold",     128'(addr_b), 128'(0));
    enable_b = 1'b1;
    t0 = base_b + 21;
    run_to(base_b + 24); check_val("t6_restart_addr0", 128'(addr_b), 128'(0));
    run_to(base_b + 25); check_val("t6_restart_addr1", 128'(addr_b), 128'(1));
    mem_b[0] = 16'd5;
    run_to(t0 + 56);       check_val("t6_retry0",   128'(retry_b), 128'(0));
    run_to(t0 + 57);       check_val("t6_retry1",   128'(retry_b), 128'(1));
    run_to(t0 + 57 * 254); check_val("t6_retry254", 128'(retry_b), 128'(254));
    run_to(t0 + 57 * 255); check_val("t6_retry255", 128'(retry_b), 128'(255));
    run_to(t0 + 57 * 260); check_val("t6_retry_sat", 128'(retry_b), 128'(255));
    check_val("t6_valid",   128'(valid_b),    128'(0));
    check_val("t6_commits", 128'(n_commit_b), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
